regs_scoreboard: RTL and testbench
==================================

# regs_scoreboard

Tracks general-purpose registers whose value is still being produced by a late-result instruction (load, multi-cycle mul/div) that has left ID, and stalls ID until they commit. Sits in the inst_decode stage beside the EX-to-ID forwarding path. That path covers single-cycle results. This block covers results that EX cannot forward. Its stall output gates the ID-to-EX issue handshake.

## Interface
- READ_PORT, 2, number of ID source operands checked
- WRITE_PORT, 1, number of commit (writeback) ports
- CNT_WIDTH, 2, width of the per-register outstanding-write counter (max 2^CNT_WIDTH-1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- id_raddr_i  in  READ_PORT x reg_addr_t  source register addresses of the instruction in ID
- id_rvalid_i  in  READ_PORT  source operand actually used
- issue_valid_i  in  1  instruction leaves ID this cycle; upstream qualifies it with !stall_o
- issue_late_i  in  1  issuing instruction's result is late (not forwardable from EX)
- issue_waddr_i  in  reg_addr_t  destination of issuing instruction
- commit_we_i  in  WRITE_PORT  late result written to register file this cycle
- commit_waddr_i  in  WRITE_PORT x reg_addr_t  commit destination
- flush_i  in  1  pipeline flush; clears all tracking
- stall_o  out  1  ID must hold
- busy_o  out  1  any register pending
- err_o  out  1  sticky: commit to a register with zero pending count

## Operation
- State: one counter per register 1..31. Register 0 is never tracked; its counter reads 0 and it is never stalled.
- Issue: when issue_valid_i && issue_late_i && issue_waddr_i != 0, counter[issue_waddr_i] increments at the next edge.
- Commit: for each j with commit_we_i[j] && commit_waddr_i[j] != 0, counter[commit_waddr_i[j]] decrements.
  - If that counter is already 0, it stays 0 and err_o sets.
  - err_o clears only on rst.
- Simultaneous issue and commit to the same register: the net change is applied; +1 and -1 leave the counter unchanged.
- Multiple commit ports hitting the same register in one cycle: each decrements; the result saturates at 0 and sets err_o if it would underflow.
- Stall conditions, combinational, from registered counters only. stall_o = any i with id_rvalid_i[i] && id_raddr_i[i] != 0 && counter[id_raddr_i[i]] != 0, OR issue_late_i && counter[issue_waddr_i] == max.
  - The second term prevents counter overflow.
  - A commit in the current cycle does not release stall in that cycle; release is the following cycle.
- issue_valid_i asserted while stall_o is high is an environment violation. The block still applies the increment if the counter is not at max; at max it ignores it.
- flush_i: all counters go to 0 at the next edge. Issue and commit in the same cycle are discarded.
  - The environment asserts flush_i only when no older late producer remains uncommitted.
- busy_o = OR of all counters != 0, registered-state based.

## Timing
- Reset (async assert): all counters 0; stall_o=0 (absent reads of pending registers), busy_o=0, err_o=0.
- Counter updates take effect 1 cycle after the issue/commit edge.
- stall_o has zero-cycle latency from id_raddr_i/id_rvalid_i; it has 1-cycle latency from issue/commit events.
- Minimum load-use bubble is set by commit timing. Example: issue at cycle N, commit at N+2 gives stall in N+1..N+2 and release in N+3.
- Reset asserted mid-operation clears everything immediately, independent of clk.

## Structure
- Shared package inst_decode.svh: reg_addr_t and uint32_t (existing); add sb_cnt_t (logic [CNT_WIDTH-1:0]) and sb_issue_t {logic valid, late; reg_addr_t waddr}.
- Sub-module regs_scoreboard_entry: one counter with inc, dec[WRITE_PORT], flush, saturation and underflow flag. Instantiated 31 times via generate. The top level does the address decode, stall reduction and err_o accumulation.

## Test plan
- Load-use: issue late to $5 at cycle 1, next ID reads $5 -> stall_o=1 cycles 2..3; commit $5 at cycle 3 -> stall_o=0 at cycle 4, busy_o=0.
- $0 destination: issue late to $0, then read $0 -> stall_o never asserts, busy_o stays 0.
- Same-cycle issue and commit to $7 with count 1 -> count stays 1, stall persists; a following commit -> count 0, stall drops next cycle.
- Saturation (CNT_WIDTH=2): three late issues to $9 -> count 3; fourth issue_late to $9 -> stall_o=1 and count stays 3; three commits -> count 0.
- Spurious commit to $12 at count 0 -> err_o=1 next cycle and stays set until rst; count remains 0.
- Flush with $3 and $4 pending, plus a concurrent issue to $6 -> all counts 0, busy_o=0 next cycle. Async rst pulse mid-stall -> stall_o drops without a clock edge.

Source files
------------

// File: rtl/regs_scoreboard_pkg.sv
// Shared decode-stage types for the late-result register scoreboard.
// Latency: none (types only); Backpressure: n/a.
package regs_scoreboard_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int SB_CNT_WIDTH = 2;

  typedef logic [REG_ADDR_W-1:0]   reg_addr_t;
  typedef logic [31:0]             uint32_t;
  typedef logic [SB_CNT_WIDTH-1:0] sb_cnt_t;

  typedef struct packed {
    logic      valid;
    logic      late;
    reg_addr_t waddr;
  } sb_issue_t;

endpackage

// File: rtl/regs_scoreboard_entry.sv
// One outstanding-write counter: +1 on issue, -1 per commit port, clear on flush.
// Latency: 1 cycle to counter; Backpressure: increment ignored at max, underflow saturates at 0 and flags.
module regs_scoreboard_entry #(
  parameter int WRITE_PORT = 1,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic [WRITE_PORT-1:0] dec,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  cnt,
  output logic                  underflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 inc_eff;
  int                   ndec;
  int                   total;

  always_comb begin
    ndec = 0;
    for (int j = 0; j < WRITE_PORT; j++) begin
      ndec = ndec + int'(dec[j]);
    end
    // An issue arriving while already at max is a protocol violation; drop it.
    inc_eff   = inc && (cnt != CNT_MAX);
    total     = int'(cnt) + int'(inc_eff);
    cnt_nxt   = cnt;
    underflow = 1'b0;
    if (flush) begin
      cnt_nxt = '0;
    end else if (total < ndec) begin
      cnt_nxt   = '0;
      underflow = 1'b1;
    end else begin
      cnt_nxt = CNT_WIDTH'(total - ndec);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regs_scoreboard.sv
// Stalls ID while a source (or a saturated destination) has a late result outstanding.
// Latency: stall is combinational on ID reads, 1 cycle from issue/commit; Backpressure: stall_o gates ID issue.
module regs_scoreboard
  import regs_scoreboard_pkg::*;
#(
  parameter int READ_PORT  = 2,
  parameter int WRITE_PORT = 1,
  parameter int CNT_WIDTH  = SB_CNT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [READ_PORT*REG_ADDR_W-1:0]   id_raddr_i,
  input  logic [READ_PORT-1:0]              id_rvalid_i,
  input  logic                              issue_valid_i,
  input  logic                              issue_late_i,
  input  logic [REG_ADDR_W-1:0]             issue_waddr_i,
  input  logic [WRITE_PORT-1:0]             commit_we_i,
  input  logic [WRITE_PORT*REG_ADDR_W-1:0]  commit_waddr_i,
  input  logic                              flush_i,
  output logic                              stall_o,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  sb_issue_t                               issue;
  logic                                    issue_hit;
  logic [NUM_REGS-1:0][CNT_WIDTH-1:0]      cnt;
  logic [NUM_REGS-1:0]                     uflow;
  logic                                    stall_rd;
  logic                                    stall_ovf;
  reg_addr_t                               ra;

  assign issue.valid = issue_valid_i;
  assign issue.late  = issue_late_i;
  assign issue.waddr = issue_waddr_i;
  assign issue_hit   = issue.valid && issue.late;

  // $0 is hardwired: never pending, never stalls.
  assign cnt[0]   = '0;
  assign uflow[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic [WRITE_PORT-1:0] dec;
    logic                  inc;

    assign inc = issue_hit && (issue.waddr == reg_addr_t'(r));
    for (genvar j = 0; j < WRITE_PORT; j++) begin : g_dec
      assign dec[j] = commit_we_i[j] &&
                      (commit_waddr_i[j*REG_ADDR_W +: REG_ADDR_W] == reg_addr_t'(r));
    end

    regs_scoreboard_entry #(
      .WRITE_PORT (WRITE_PORT),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc),
      .dec       (dec),
      .flush     (flush_i),
      .cnt       (cnt[r]),
      .underflow (uflow[r])
    );
  end

  always_comb begin
    stall_rd = 1'b0;
    ra       = '0;
    for (int i = 0; i < READ_PORT; i++) begin
      ra = id_raddr_i[i*REG_ADDR_W +: REG_ADDR_W];
      if (id_rvalid_i[i] && (ra != '0) && (cnt[ra] != '0)) begin
        stall_rd = 1'b1;
      end
    end
  end

  // Holding a late writer whose counter is full keeps the counter from wrapping.
  assign stall_ovf = issue_late_i && (cnt[issue_waddr_i] == CNT_MAX);
  assign stall_o   = stall_rd || stall_ovf;
  assign busy_o    = |cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (|uflow) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regs_scoreboard.sv
// Directed bench for regs_scoreboard with a pending-count model and per-cycle compare.
// Latency: n/a; Backpressure: n/a.
module tb_regs_scoreboard;

  localparam int MAXC = 3;

  logic        clk;
  logic        rst;
  logic [9:0]  id_raddr_i;
  logic [1:0]  id_rvalid_i;
  logic        issue_valid_i;
  logic        issue_late_i;
  logic [4:0]  issue_waddr_i;
  logic [0:0]  commit_we_i;
  logic [4:0]  commit_waddr_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        err_o;

  int   n_checks;
  int   n_errors;
  int   model_cnt [32];
  logic model_err;

  regs_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .id_raddr_i     (id_raddr_i),
    .id_rvalid_i    (id_rvalid_i),
    .issue_valid_i  (issue_valid_i),
    .issue_late_i   (issue_late_i),
    .issue_waddr_i  (issue_waddr_i),
    .commit_we_i    (commit_we_i),
    .commit_waddr_i (commit_waddr_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: pending late writes per architectural register.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) model_cnt[r] = 0;
      model_err = 1'b0;
    end else if (flush_i) begin
      for (int r = 0; r < 32; r++) model_cnt[r] = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        int up;
        int down;
        up   = (issue_valid_i && issue_late_i && issue_waddr_i == r && model_cnt[r] < MAXC) ? 1 : 0;
        down = (commit_we_i[0] && commit_waddr_i == r) ? 1 : 0;
        if (model_cnt[r] + up < down) begin
          model_cnt[r] = 0;
          model_err    = 1'b1;
        end else begin
          model_cnt[r] = model_cnt[r] + up - down;
        end
      end
    end
  end

  function automatic logic model_stall();
    logic s;
    int   a;
    s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = int'(id_raddr_i[i*5 +: 5]);
      if (id_rvalid_i[i] && a != 0 && model_cnt[a] != 0) s = 1'b1;
    end
    if (issue_late_i && model_cnt[issue_waddr_i] == MAXC) s = 1'b1;
    return s;
  endfunction

  function automatic logic model_busy();
    logic b;
    b = 1'b0;
    for (int r = 0; r < 32; r++) if (model_cnt[r] != 0) b = 1'b1;
    return b;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("stall_vs_model", stall_o, model_stall());
      chk("busy_vs_model",  busy_o,  model_busy());
      chk("err_vs_model",   err_o,   model_err);
    end
  end

  // Waits for the next edge, applies one cycle of inputs, then settles before literal checks.
  task automatic step(input logic [4:0] r0, input logic v0, input logic [4:0] r1, input logic v1,
                      input logic iv, input logic il, input logic [4:0] iw,
                      input logic cwe, input logic [4:0] cw, input logic fl);
    @(posedge clk);
    #1;
    id_raddr_i     = {r1, r0};
    id_rvalid_i    = {v1, v0};
    issue_valid_i  = iv;
    issue_late_i   = il;
    issue_waddr_i  = iw;
    commit_we_i[0] = cwe;
    commit_waddr_i = cw;
    flush_i        = fl;
    #2;
  endtask

  task automatic idle();
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst            = 1'b1;
    id_raddr_i     = '0;
    id_rvalid_i    = '0;
    issue_valid_i  = 1'b0;
    issue_late_i   = 1'b0;
    issue_waddr_i  = '0;
    commit_we_i    = '0;
    commit_waddr_i = '0;
    flush_i        = 1'b0;
    #3;
    chk("reset_stall", stall_o, 1'b0);
    chk("reset_busy",  busy_o,  1'b0);
    chk("reset_err",   err_o,   1'b0);
    #5;
    rst = 1'b0;

    // Load-use on $5: issue, two stalled reads (commit in the second), release.
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
    chk("lu_issue_nostall", stall_o, 1'b0);
    step(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("lu_stall_c2", stall_o, 1'b1);
    chk("lu_busy_c2",  busy_o,  1'b1);
    step(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
    chk("lu_stall_c3_commit", stall_o, 1'b1);
    step(5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("lu_release_c4", stall_o, 1'b0);
    chk("lu_idle_c4",    busy_o,  1'b0);

    // $0 is never tracked.
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("r0_nostall", stall_o, 1'b0);
    chk("r0_notbusy", busy_o,  1'b0);

    // $7: same-cycle issue and commit leaves count at 1.
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0);
    step(5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk_int("model_cnt7_after_same_cycle", model_cnt[7], 1);
    chk("r7_stall_persists", stall_o, 1'b1);
    step(5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
    chk("r7_stall_commit_cycle", stall_o, 1'b1);
    step(5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("r7_released", stall_o, 1'b0);

    // $9 saturation at 3; a fourth late issue stalls and is dropped.
    for (int k = 0; k < 3; k++) step(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
    chk_int("model_cnt9_full", model_cnt[9], 3);
    chk("r9_overflow_stall", stall_o, 1'b1);
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
    chk_int("model_cnt9_held", model_cnt[9], 3);
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
    chk("r9_busy_before_last", busy_o, 1'b1);
    step(5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("r9_drained_nostall", stall_o, 1'b0);
    chk("r9_drained_idle",    busy_o,  1'b0);

    // Spurious commit to $12 sets sticky err.
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd12, 1'b0);
    chk("err_before", err_o, 1'b0);
    idle();
    chk("err_set", err_o, 1'b1);
    chk_int("model_cnt12_zero", model_cnt[12], 0);
    idle();
    idle();
    chk("err_sticky", err_o, 1'b1);

    // Flush with $3,$4 pending and a concurrent issue to $6.
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0);
    step(5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1);
    chk("flush_cycle_stall", stall_o, 1'b1);
    step(5'd6, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("post_flush_nostall", stall_o, 1'b0);
    chk("post_flush_idle",    busy_o,  1'b0);

    // Async reset mid-stall, between clock edges.
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
    step(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("pre_rst_stall", stall_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_stall", stall_o, 1'b0);
    chk("async_rst_busy",  busy_o,  1'b0);
    chk("async_rst_err",   err_o,   1'b0);
    rst = 1'b0;
    idle();
    chk("after_rst_err", err_o, 1'b0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
